jtlb_lookup: RTL and testbench

//  Main joint TLB (JTLB) and refill engine behind the MMU's single-entry STLB. On an MMU miss request it

---
 rtl/jtlb_lookup_pkg.sv | 64 ++++++
 rtl/jtlb_lookup_if.sv | 47 ++++
 rtl/jtlb_lookup_match.sv | 45 ++++
 rtl/jtlb_lookup.sv | 220 ++++++++++++++++++++++
 tb/tb_jtlb_lookup.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtlb_lookup_pkg.sv
// Shared types for the joint TLB (JTLB) lookup / refill engine.
//   jtlb_entry_t : one JTLB entry pair, 94 bits
//                  {VPN2[18:0], ASID, Mask[15:0], G, PFN0, C0, D0, V0, PFN1, C1, D1, V1}
//   stlb_entry_t : refill word for the single-entry STLB, 74 bits
//                  {VPN[19:0], PFN[19:0], Mask[19:0], ASID, G, V, D, C[2:0]}
//   state_t      : FSM encodings, op_t : operation being served
//   dbg_t        : FSM observation bundle exported by the top
package jtlb_lookup_pkg;

    localparam int JTLB_W = 94;
    localparam int STLB_W = 74;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [15:0] mask;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } jtlb_entry_t;

    typedef struct packed {
        logic [19:0] vpn;
        logic [19:0] pfn;
        logic [19:0] mask;
        logic [7:0]  asid;
        logic        g;
        logic        v;
        logic        d;
        logic [2:0]  c;
    } stlb_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_RESP  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef enum logic {
        OP_LOOKUP = 1'b0,
        OP_PROBE  = 1'b1
    } op_t;

    typedef struct packed {
        state_t     state;
        op_t        op;
        logic [6:0] scan_idx;
        logic       hit_odd;
    } dbg_t;

    // The bit just above the page mask selects the odd page of the pair.
    // va_bits is va[28:12].
    function automatic logic odd_page(input logic [16:0] va_bits, input logic [15:0] mask);
        return |(va_bits & ({1'b0, mask} + 17'd1));
    endfunction

endpackage

// File: rtl/jtlb_lookup_if.sv
// Bus bundle between the MMU/CP0 side (master) and the JTLB engine (slave).
//   Lookup : tlb_en, tlb_vaddr, EntryHi -> stlb_wen, stlb_wdata, stlb_inv, tlb_tlbr, tlb_tlbi
//   Write  : tlbw_en, tlbw_idx, tlbw_data
//   Read   : tlbr_idx -> tlbr_data (combinational)
//   Probe  : tlbp_en -> tlbp_done, tlbp_miss, tlbp_idx
// Handshake: tlb_en and tlbp_en are level requests. The master holds a request
// high until its completion (stlb_wen pulse, or tlb_tlbr/tlb_tlbi fault for a
// lookup; tlbp_done pulse for a probe) and drops it afterwards. Dropping tlb_en
// early aborts the lookup. tlbw_en is a single-cycle strobe with no back-pressure.
interface jtlb_lookup_if #(
    parameter int TLB_ENTRIES = 16
);
    import jtlb_lookup_pkg::*;

    localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

    logic             tlb_en;
    logic [31:0]      tlb_vaddr;
    logic [31:0]      EntryHi;
    logic             stlb_wen;
    stlb_entry_t      stlb_wdata;
    logic             stlb_inv;
    logic             tlb_tlbr;
    logic             tlb_tlbi;
    logic             tlbw_en;
    logic [IDX_W-1:0] tlbw_idx;
    jtlb_entry_t      tlbw_data;
    logic [IDX_W-1:0] tlbr_idx;
    jtlb_entry_t      tlbr_data;
    logic             tlbp_en;
    logic             tlbp_done;
    logic             tlbp_miss;
    logic [IDX_W-1:0] tlbp_idx;

    modport master (
        output tlb_en, tlb_vaddr, EntryHi, tlbw_en, tlbw_idx, tlbw_data, tlbr_idx, tlbp_en,
        input  stlb_wen, stlb_wdata, stlb_inv, tlb_tlbr, tlb_tlbi, tlbr_data,
               tlbp_done, tlbp_miss, tlbp_idx
    );

    modport slave (
        input  tlb_en, tlb_vaddr, EntryHi, tlbw_en, tlbw_idx, tlbw_data, tlbr_idx, tlbp_en,
        output stlb_wen, stlb_wdata, stlb_inv, tlb_tlbr, tlb_tlbi, tlbr_data,
               tlbp_done, tlbp_miss, tlbp_idx
    );

endinterface

// File: rtl/jtlb_lookup_match.sv
// Compare one JTLB entry against a VPN/ASID and format the STLB refill word.
//   entry : JTLB entry under test
//   vpn   : va[31:12] (for a probe, {VPN2, 1'b0})
//   asid  : ASID to compare when the entry is not global
//   match : entry translates this address
//   odd   : odd page of the pair is selected
//   stlb  : refill word built from the selected page
module jtlb_match
    import jtlb_lookup_pkg::*;
(
    input  jtlb_entry_t entry,
    input  logic [19:0] vpn,
    input  logic [7:0]  asid,
    output logic        match,
    output logic        odd,
    output stlb_entry_t stlb
);

    logic [18:0] mask19;

    assign mask19 = {3'b000, entry.mask};
    assign match  = ((entry.vpn2 & ~mask19) == (vpn[19:1] & ~mask19))
                    && (entry.g || (entry.asid == asid));
    assign odd    = odd_page(vpn[16:0], entry.mask);

    always_comb begin
        stlb      = '0;
        stlb.vpn  = vpn;
        stlb.mask = {4'b0000, entry.mask};
        stlb.asid = entry.asid;
        stlb.g    = entry.g;
        if (odd) begin
            stlb.pfn = entry.pfn1;
            stlb.c   = entry.c1;
            stlb.d   = entry.d1;
            stlb.v   = entry.v1;
        end else begin
            stlb.pfn = entry.pfn0;
            stlb.c   = entry.c0;
            stlb.d   = entry.d0;
            stlb.v   = entry.v0;
        end
    end

endmodule

// File: rtl/jtlb_lookup.sv
// JTLB and refill engine behind the single-entry STLB.
// Serves MMU miss lookups (refill or TLB Refill/Invalid fault), TLBWI/TLBWR
// writes, TLBR reads and TLBP probes. Any write invalidates the STLB.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : jtlb_lookup_if slave (lookup, write, read, probe channels)
//   dbg        : FSM state, operation, scan index, odd-page flag of last hit
// Build option: TLB_PARALLEL_EN compares all entries in one SCAN cycle with a
// lowest-index priority encode; otherwise one entry is compared per cycle.
module jtlb_lookup
    import jtlb_lookup_pkg::*;
#(
    parameter int TLB_ENTRIES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    jtlb_lookup_if.slave  bus,
    output dbg_t          dbg
);

    localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

    jtlb_entry_t      mem [TLB_ENTRIES];

    state_t           state;
    op_t              op;
    logic [19:0]      vpn_q;
    logic [7:0]       asid_q;
    logic [IDX_W-1:0] idx_q;
    stlb_entry_t      hit_word_q;
    logic [IDX_W-1:0] hit_idx_q;
    logic             hit_miss_q;
    logic             hit_odd_q;
    logic             tlbr_q;
    logic             tlbi_q;
    logic             inv_q;

    logic             found;
    logic             found_odd;
    logic [IDX_W-1:0] found_idx;
    stlb_entry_t      found_word;
    logic             scan_last;
    logic             lookup_abort;
    logic             restart_va;

    // Entry storage: written at the clock edge, read combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.tlbw_en) begin
            mem[bus.tlbw_idx] <= bus.tlbw_data;
        end
    end

    assign bus.tlbr_data = mem[bus.tlbr_idx];

`ifdef TLB_PARALLEL_EN
    logic [TLB_ENTRIES-1:0] match_vec;
    logic [TLB_ENTRIES-1:0] odd_vec;
    stlb_entry_t            word_vec [TLB_ENTRIES];

    for (genvar g = 0; g < TLB_ENTRIES; g++) begin : g_match
        jtlb_match u_match (
            .entry (mem[g]),
            .vpn   (vpn_q),
            .asid  (asid_q),
            .match (match_vec[g]),
            .odd   (odd_vec[g]),
            .stlb  (word_vec[g])
        );
    end

    // Descending walk so the lowest matching index is the one left standing.
    always_comb begin
        found      = 1'b0;
        found_odd  = 1'b0;
        found_idx  = '0;
        found_word = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                found      = 1'b1;
                found_odd  = odd_vec[i];
                found_idx  = IDX_W'(i);
                found_word = word_vec[i];
            end
        end
    end

    assign scan_last = 1'b1;
`else
    jtlb_match u_match (
        .entry (mem[idx_q]),
        .vpn   (vpn_q),
        .asid  (asid_q),
        .match (found),
        .odd   (found_odd),
        .stlb  (found_word)
    );

    assign found_idx = idx_q;
    assign scan_last = (idx_q == IDX_W'(TLB_ENTRIES - 1));
`endif

    // A lookup is abandoned when the MMU drops its request, and re-issued from
    // entry 0 when the MMU moves to a different page while still requesting.
    assign lookup_abort = (op == OP_LOOKUP) && !bus.tlb_en;
    assign restart_va   = (op == OP_LOOKUP) && bus.tlb_en && (bus.tlb_vaddr[31:12] != vpn_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op         <= OP_LOOKUP;
            vpn_q      <= '0;
            asid_q     <= '0;
            idx_q      <= '0;
            hit_word_q <= '0;
            hit_idx_q  <= '0;
            hit_miss_q <= 1'b0;
            hit_odd_q  <= 1'b0;
            tlbr_q     <= 1'b0;
            tlbi_q     <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            inv_q <= bus.tlbw_en;
            unique case (state)
                ST_IDLE: begin
                    tlbr_q <= 1'b0;
                    tlbi_q <= 1'b0;
                    if (bus.tlb_en) begin
                        vpn_q  <= bus.tlb_vaddr[31:12];
                        asid_q <= bus.EntryHi[7:0];
                        op     <= OP_LOOKUP;
                        idx_q  <= '0;
                        state  <= ST_SCAN;
                    end else if (bus.tlbp_en) begin
                        vpn_q  <= {bus.EntryHi[31:13], 1'b0};
                        asid_q <= bus.EntryHi[7:0];
                        op     <= OP_PROBE;
                        idx_q  <= '0;
                        state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (lookup_abort) begin
                        state <= ST_IDLE;
                    end else if (restart_va) begin
                        vpn_q  <= bus.tlb_vaddr[31:12];
                        asid_q <= bus.EntryHi[7:0];
                        idx_q  <= '0;
                    end else if (bus.tlbw_en) begin
                        // Entry table is changing under us: start over.
                        idx_q <= '0;
                    end else if (found) begin
                        hit_word_q <= found_word;
                        hit_idx_q  <= found_idx;
                        hit_miss_q <= 1'b0;
                        hit_odd_q  <= found_odd;
                        state      <= ST_RESP;
                    end else if (scan_last) begin
                        if (op == OP_LOOKUP) begin
                            tlbr_q <= 1'b1;
                            state  <= ST_FAULT;
                        end else begin
                            hit_idx_q  <= '0;
                            hit_miss_q <= 1'b1;
                            state      <= ST_RESP;
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (lookup_abort) begin
                        state <= ST_IDLE;
                    end else if (restart_va) begin
                        vpn_q  <= bus.tlb_vaddr[31:12];
                        asid_q <= bus.EntryHi[7:0];
                        idx_q  <= '0;
                        state  <= ST_SCAN;
                    end else if (bus.tlbw_en) begin
                        idx_q <= '0;
                        state <= ST_SCAN;
                    end else if ((op == OP_LOOKUP) && !hit_word_q.v) begin
                        tlbi_q <= 1'b1;
                        state  <= ST_FAULT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (!bus.tlb_en) begin
                        tlbr_q <= 1'b0;
                        tlbi_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Completion strobes are qualified by the current cycle's inputs so that an
    // abort, restart or table write in the RESP cycle never lets a stale result out.
    assign bus.stlb_wen   = (state == ST_RESP) && (op == OP_LOOKUP) && bus.tlb_en
                            && !restart_va && !bus.tlbw_en && hit_word_q.v;
    assign bus.stlb_wdata = hit_word_q;
    assign bus.stlb_inv   = inv_q;
    assign bus.tlb_tlbr   = tlbr_q;
    assign bus.tlb_tlbi   = tlbi_q;
    assign bus.tlbp_done  = (state == ST_RESP) && (op == OP_PROBE) && !bus.tlbw_en;
    assign bus.tlbp_miss  = bus.tlbp_done && hit_miss_q;
    assign bus.tlbp_idx   = bus.tlbp_done ? hit_idx_q : '0;

    assign dbg.state    = state;
    assign dbg.op       = op;
    assign dbg.scan_idx = 7'(idx_q);
    assign dbg.hit_odd  = hit_odd_q;

endmodule

// File: tb/tb_jtlb_lookup.sv
module tb_jtlb_lookup;
    import jtlb_lookup_pkg::*;

    localparam int N     = 16;
    localparam int IDX_W = $clog2(N);
    localparam int EW    = 32 + STLB_W;
    localparam int PW    = 32 + 1 + IDX_W;
`ifdef TLB_PARALLEL_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    dbg_t dbg;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jtlb_lookup_if #(.TLB_ENTRIES(N)) bus ();

    jtlb_lookup #(.TLB_ENTRIES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .dbg   (dbg)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected latencies from the first tlb_en/tlbp_en cycle.
    function automatic int hit_lat(input int i);
        return PAR ? 2 : i + 2;
    endfunction

    function automatic int miss_lat();
        return PAR ? 2 : N + 1;
    endfunction

    function automatic jtlb_entry_t mke(
        input logic [18:0] vpn2, input logic [7:0] asid, input logic [15:0] mask, input logic g,
        input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
        input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
        jtlb_entry_t e;
        e.vpn2 = vpn2; e.asid = asid; e.mask = mask; e.g = g;
        e.pfn0 = pfn0; e.c0 = c0; e.d0 = d0; e.v0 = v0;
        e.pfn1 = pfn1; e.c1 = c1; e.d1 = d1; e.v1 = v1;
        return e;
    endfunction

    function automatic stlb_entry_t mkw(
        input logic [19:0] vpn, input logic [19:0] pfn, input logic [19:0] mask,
        input logic [7:0] asid, input logic g, input logic v, input logic d, input logic [2:0] c);
        stlb_entry_t w;
        w.vpn = vpn; w.pfn = pfn; w.mask = mask; w.asid = asid;
        w.g = g; w.v = v; w.d = d; w.c = c;
        return w;
    endfunction

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [PW-1:0] probe_q[$];

    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [PW-1:0] p;
        if (rst_n) begin
            if (exp_q.size() == 0) begin
                check("no_wen", bus.stlb_wen, 1'b0);
            end else if (bus.stlb_wen) begin
                e = exp_q.pop_front();
                check("wen_cycle", cyc, e[EW-1 -: 32]);
                check("wen_word", bus.stlb_wdata, e[STLB_W-1:0]);
            end
            if (probe_q.size() == 0) begin
                check("no_probe_done", bus.tlbp_done, 1'b0);
            end else if (bus.tlbp_done) begin
                p = probe_q.pop_front();
                check("probe_cycle", cyc, p[PW-1 -: 32]);
                check("probe_result", {bus.tlbp_miss, bus.tlbp_idx}, p[IDX_W:0]);
            end
            check("wen_inv_excl", bus.stlb_wen & bus.stlb_inv, 1'b0);
            check("fault_excl", bus.tlb_tlbr & bus.tlb_tlbi, 1'b0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_entry(input int idx, input jtlb_entry_t e);
        @(posedge clk); #1;
        bus.tlbw_en   = 1'b1;
        bus.tlbw_idx  = IDX_W'(idx);
        bus.tlbw_data = e;
        @(posedge clk); #1;
        bus.tlbw_en = 1'b0;
        @(negedge clk);
        check("stlb_inv_after_write", bus.stlb_inv, 1'b1);
    endtask

    task automatic wait_wen_and_release();
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = bus.stlb_wen;
        end
        check("wen_seen", seen, 1'b1);
        #1;
        bus.tlb_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic lookup_hit(input logic [31:0] va, input logic [7:0] asid,
                              input int lat, input stlb_entry_t w);
        int c0;
        @(posedge clk); #1;
        bus.EntryHi   = {24'h0, asid};
        bus.tlb_vaddr = va;
        bus.tlb_en    = 1'b1;
        c0 = cyc;
        exp_q.push_back({32'(c0 + lat), w});
        wait_wen_and_release();
    endtask

    task automatic lookup_fault(input logic [31:0] va, input logic [7:0] asid,
                                input int lat, input logic [1:0] kind);
        int  c0;
        bit  seen = 1'b0;
        @(posedge clk); #1;
        bus.EntryHi   = {24'h0, asid};
        bus.tlb_vaddr = va;
        bus.tlb_en    = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = bus.tlb_tlbr | bus.tlb_tlbi;
        end
        check("fault_seen", seen, 1'b1);
        check("fault_cycle", cyc - c0, lat);
        check("fault_kind", {bus.tlb_tlbr, bus.tlb_tlbi}, kind);
        repeat (3) @(negedge clk);
        check("fault_hold", {bus.tlb_tlbr, bus.tlb_tlbi}, kind);
        #1;
        bus.tlb_en = 1'b0;
        @(negedge clk);
        check("fault_clear", {bus.tlb_tlbr, bus.tlb_tlbi}, 2'b00);
    endtask

    task automatic probe(input logic [18:0] vpn2, input logic [7:0] asid, input int lat,
                         input logic miss, input int idx);
        int c0;
        bit seen = 1'b0;
        @(posedge clk); #1;
        bus.EntryHi = {vpn2, 5'h0, asid};
        bus.tlbp_en = 1'b1;
        c0 = cyc;
        probe_q.push_back({32'(c0 + lat), miss, IDX_W'(idx)});
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = bus.tlbp_done;
        end
        check("probe_seen", seen, 1'b1);
        #1;
        bus.tlbp_en = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    jtlb_entry_t e5, e5g, e7, e9, e2;
    stlb_entry_t w1, w3, w4, w5;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int w_off;
        bus.tlb_en    = 1'b0;
        bus.tlb_vaddr = '0;
        bus.EntryHi   = '0;
        bus.tlbw_en   = 1'b0;
        bus.tlbw_idx  = '0;
        bus.tlbw_data = '0;
        bus.tlbr_idx  = IDX_W'(5);
        bus.tlbp_en   = 1'b0;

        e5  = mke(19'h00040, 8'd3, 16'h0000, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h54321, 3'd2, 1'b0, 1'b0);
        e5g = mke(19'h00040, 8'd3, 16'h0000, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h54321, 3'd2, 1'b0, 1'b0);
        e7  = mke(19'h00040, 8'd3, 16'h0003, 1'b0, 20'h0AAAA, 3'd1, 1'b1, 1'b1, 20'h0ABCD, 3'd2, 1'b0, 1'b1);
        e9  = mke(19'h00100, 8'd3, 16'h0000, 1'b0, 20'h09999, 3'd5, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
        e2  = mke(19'h00100, 8'd3, 16'h0000, 1'b0, 20'h02222, 3'd6, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
        w1  = mkw(20'h00080, 20'h12345, 20'h00000, 8'd3, 1'b0, 1'b1, 1'b1, 3'd3);
        w3  = mkw(20'h00080, 20'h12345, 20'h00000, 8'd3, 1'b1, 1'b1, 1'b1, 3'd3);
        w4  = mkw(20'h00084, 20'h0ABCD, 20'h00003, 8'd3, 1'b0, 1'b1, 1'b0, 3'd2);
        w5  = mkw(20'h00200, 20'h02222, 20'h00000, 8'd3, 1'b0, 1'b1, 1'b1, 3'd6);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {bus.stlb_wen, bus.stlb_inv, bus.tlb_tlbr, bus.tlb_tlbi,
                              bus.tlbp_done, bus.tlbp_miss}, 6'b0);
        check("rst_wdata", bus.stlb_wdata, '0);
        check("rst_tlbr_data", bus.tlbr_data, '0);
        check("rst_state", dbg.state, ST_IDLE);
        rst_n = 1'b1;
        @(posedge clk); #1;

        write_entry(5, e5);
        write_entry(7, e7);
        write_entry(9, e9);
        bus.tlbr_idx = IDX_W'(5);
        #1;
        check("tlbr_read5", bus.tlbr_data, e5);
        bus.tlbr_idx = IDX_W'(7);
        #1;
        check("tlbr_read7", bus.tlbr_data, e7);

        // Even-page refill from entry 5
        lookup_hit(32'h0008_0010, 8'd3, hit_lat(5), w1);
        // Odd page of entry 5 is invalid
        lookup_fault(32'h0008_1000, 8'd3, hit_lat(5) + 1, 2'b01);
        // ASID mismatch -> refill fault, then global entry refills
        lookup_fault(32'h0008_0010, 8'd4, miss_lat(), 2'b10);
        write_entry(5, e5g);
        lookup_hit(32'h0008_0010, 8'd4, hit_lat(5), w3);
        // Masked entry, odd page picked by va[14]
        lookup_hit(32'h0008_4000, 8'd3, hit_lat(7), w4);

        // Abort: request dropped after two cycles, no refill and no fault
        @(posedge clk); #1;
        bus.EntryHi   = 32'h3;
        bus.tlb_vaddr = 32'h0020_0000;
        bus.tlb_en    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.tlb_en = 1'b0;
        repeat (N + 4) @(posedge clk);
        @(negedge clk);
        check("abort_state", dbg.state, ST_IDLE);
        check("abort_faults", {bus.tlb_tlbr, bus.tlb_tlbi}, 2'b00);

        // Write during a scan: restart, and the new lower entry 2 wins
        w_off = PAR ? 1 : 10;
        @(posedge clk); #1;
        bus.EntryHi   = 32'h3;
        bus.tlb_vaddr = 32'h0020_0000;
        bus.tlb_en    = 1'b1;
        c0 = cyc;
        exp_q.push_back({32'(c0 + w_off + hit_lat(2)), w5});
        repeat (w_off) @(posedge clk);
        #1;
        bus.tlbw_en   = 1'b1;
        bus.tlbw_idx  = IDX_W'(2);
        bus.tlbw_data = e2;
        @(posedge clk); #1;
        bus.tlbw_en = 1'b0;
        @(negedge clk);
        check("inv_during_scan", bus.stlb_inv, 1'b1);
        wait_wen_and_release();

        // Probes: hit on entry 5, then a miss
        probe(19'h00040, 8'd3, hit_lat(5), 1'b0, 5);
        probe(19'h7FFFF, 8'd3, miss_lat(), 1'b1, 0);

        // Reset in the middle of a lookup
        @(posedge clk); #1;
        bus.EntryHi   = 32'h3;
        bus.tlb_vaddr = 32'h0020_0000;
        bus.tlb_en    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_state", dbg.state, ST_IDLE);
        check("midrst_outputs", {bus.stlb_wen, bus.stlb_inv, bus.tlb_tlbr, bus.tlb_tlbi,
                                 bus.tlbp_done}, 5'b0);
        bus.tlbr_idx = IDX_W'(2);
        #1;
        check("midrst_table_clear", bus.tlbr_data, '0);
        bus.tlb_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        check("exp_q_empty", exp_q.size(), 0);
        check("probe_q_empty", probe_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
